// File: rtl/multiplier_seq_block.sv
// Sequential shift-and-add multiplier: o_data0 = i_data0 * i_coef mod 2^WIDTH.
// One coefficient bit is consumed per clock while BUSY; the product is held in
// DONE until the consumer asserts i_ready.
// Build option: define MULT_SEQ_EARLY_EXIT_EN to leave BUSY as soon as no set
// coefficient bits remain (results are identical, only latency changes).
module multiplier_seq_block #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COEF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_data0,
  input  logic [COEF_W-1:0] i_coef,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [WIDTH-1:0]  o_data0,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int unsigned    CntW    = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(COEF_W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_step;

  // Final BUSY step: all coefficient bits consumed (or, with early exit, none left set).
`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign last_step = (cnt_q == CntLast) || ((coef_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CntLast);
`endif

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      coef_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      coef_q  <= coef_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; operands are captured only on acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    coef_d  = coef_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          acc_d   = '0;
          mcand_d = i_data0;
          coef_d  = i_coef;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Carries beyond WIDTH bits are dropped by the sized add and shift.
        if (coef_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        coef_d  = coef_q >> 1;
        cnt_d   = cnt_q + CntOne;
        if (last_step) state_d = StDone;
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    o_ready = (state_q == StIdle);
    o_busy  = (state_q == StBusy);
    o_valid = (state_q == StDone);
    o_data0 = acc_q;
  end

endmodule

// File: tb/tb_multiplier_seq_block.sv
// Self-checking bench for multiplier_seq_block (WIDTH=32, COEF_W=16).
// Expected products and latencies are queued when operands are driven and
// popped when the result appears. Honours MULT_SEQ_EARLY_EXIT_EN for latency.
module tb_multiplier_seq_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data0;
  logic [15:0] i_coef;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_data0;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  multiplier_seq_block #(
    .WIDTH (32),
    .COEF_W(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_data0(i_data0),
    .i_coef (i_coef),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data0(o_data0),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_busy (o_busy)
  );

  function automatic int exp_latency(input logic [15:0] c);
    int hi;
    hi = 0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    for (int b = 0; b < 16; b++) if (c[b]) hi = b + 1;
    if (hi < 1) hi = 1;
`else
    hi = 16;
`endif
    return hi;
  endfunction

  // Drives one operand pair at a negedge; returns at the negedge after the edge.
  task automatic accept(input logic [31:0] d, input logic [15:0] c, output bit was_ready);
    logic [31:0] prod;
    was_ready = o_ready;
    i_data0 = d;
    i_coef  = c;
    i_valid = 1'b1;
    prod    = d * {16'h0, c};
    exp_q.push_back(prod);
    lat_q.push_back(exp_latency(c));
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_data0 = $urandom;
    i_coef  = 16'($urandom);
  endtask

  // Counts edges until o_valid, bounded.
  task automatic wait_valid(output int lat, output bit timeout);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    timeout = !o_valid;
  endtask

  // Full transaction with consumer always ready.
  task automatic run_txn(input logic [31:0] d, input logic [15:0] c, input string name);
    bit          rdy, tmo;
    int          lat, elat;
    logic [31:0] eprod;
    i_ready = 1'b1;
    accept(d, c, rdy);
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_at_accept got %b want 1", name, rdy);
    end
    n_checks++;
    if (!o_valid && o_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_accept got %b want 1", name, o_busy);
    end
    wait_valid(lat, tmo);
    eprod = exp_q.pop_front();
    elat  = lat_q.pop_front();
    n_checks++;
    if (tmo) begin
      n_fail++; $display("FAIL %s valid_timeout got no o_valid want o_valid", name);
    end
    n_checks++;
    if (lat != elat) begin
      n_fail++; $display("FAIL %s latency got %0d want %0d", name, lat, elat);
    end
    n_checks++;
    if (o_data0 !== eprod) begin
      n_fail++; $display("FAIL %s product got %h want %h", name, o_data0, eprod);
    end
    n_checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s done_flags got rdy=%b busy=%b want 0/0", name, o_ready, o_busy);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s pulse_end got vld=%b rdy=%b want 0/1", name, o_valid, o_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data0 = '0; i_coef = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b data=%h want 1/0/0/0",
               o_ready, o_valid, o_busy, o_data0);
    end
  endtask

  task automatic test_basic();
    run_txn(32'd1, 16'd23027, "basic_23027");
    run_txn(32'hFFFF_FFFF, 16'd3, "wrap");
    run_txn(32'd5, 16'd1, "coef_one");
    run_txn(32'd12345, 16'd0, "coef_zero");
    run_txn(32'd0, 16'hFFFF, "data_zero");
    run_txn(32'hDEAD_BEEF, 16'h8000, "coef_msb");
  endtask

  task automatic test_backpressure();
    bit rdy, tmo;
    int lat;
    logic [31:0] eprod;
    i_ready = 1'b0;
    accept(32'd100, 16'd700, rdy);
    wait_valid(lat, tmo);
    eprod = exp_q.pop_front();
    void'(lat_q.pop_front());
    n_checks++;
    if (tmo) begin
      n_fail++; $display("FAIL bp_timeout got no o_valid want o_valid");
    end
    for (int i = 0; i < 5; i++) begin
      i_valid = i[0];
      i_data0 = 32'd9;
      i_coef  = 16'd9;
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data0 !== eprod) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b data=%0d want 1/0/%0d",
                 i, o_valid, o_ready, o_data0, eprod);
      end
      @(posedge clk);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b want 0/1/0", o_valid, o_ready, o_busy);
    end
  endtask

  task automatic test_reset_abort();
    bit rdy;
    int seen;
    i_ready = 1'b1;
    accept(32'hABCD, 16'hFFFF, rdy);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    n_checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b rdy=%b vld=%b data=%h want 0/1/0/0",
               o_busy, o_ready, o_valid, o_data0);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (o_valid || o_busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_result got %0d active cycles want 0", seen);
    end
    run_txn(32'd7, 16'd6, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_txn($urandom, 16'($urandom), "b2b_random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data0 = '0; i_coef = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_block.md
MULTIPLIER_SEQ_BLOCK -- requirements
Module: multiplier_seq_block

Interface
REQ-001 Parameter WIDTH, default 32: multiplicand and product width in bits.
REQ-002 Parameter COEF_W, default 16: coefficient width in bits; legal range 1..WIDTH.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port i_data0, input, WIDTH: multiplicand, sampled at acceptance.
REQ-006 Port i_coef, input, COEF_W: unsigned coefficient, sampled at acceptance.
REQ-007 Port i_valid, input, 1: operand pair valid.
REQ-008 Port o_ready, output, 1: block can accept operands.
REQ-009 Port o_data0, output, WIDTH: product, i_data0*i_coef mod 2^WIDTH.
REQ-010 Port o_valid, output, 1: o_data0 valid.
REQ-011 Port i_ready, input, 1: downstream consumes the result.
REQ-012 Port o_busy, output, 1: high while the block is in BUSY.

Function
REQ-013 Three states: IDLE, BUSY, DONE.
REQ-014 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE; o_busy SHALL be 1 only in BUSY.
REQ-015 Acceptance is i_valid && o_ready at a rising edge.
REQ-016 On acceptance: acc<=0, mcand<=i_data0, coef_reg<=i_coef, cnt<=0, state<=BUSY.
REQ-017 Each BUSY edge: if coef_reg[0] then acc<=acc+mcand; mcand<=mcand<<1; coef_reg<=coef_reg>>1; cnt<=cnt+1.
REQ-018 All arithmetic is WIDTH bits, unsigned; carries out of bit WIDTH-1 are discarded.
REQ-019 BUSY->DONE on the edge where cnt==COEF_W-1, so the result is valid COEF_W edges after the acceptance edge.
REQ-020 In DONE, o_data0 SHALL equal acc and stay stable until consumed.
REQ-021 DONE->IDLE on the edge where i_ready==1; o_valid is allowed to fall on that edge.
REQ-022 Back-to-back: the next acceptance is possible no earlier than the edge after DONE->IDLE; there is no overlap.
REQ-023 i_data0 and i_coef changes outside the acceptance edge SHALL have no effect.
REQ-024 i_valid in BUSY or DONE SHALL be ignored, and no operand SHALL be captured.
REQ-025 i_coef==0 SHALL produce o_data0==0; i_data0==0 SHALL produce 0.

Reset
REQ-026 rst==1 at an edge SHALL force state IDLE, acc=0, mcand=0, coef_reg=0, cnt=0, and override every other transition.
REQ-027 Output reset values: o_data0=0, o_valid=0, o_ready=1 in the cycle after the reset edge, o_busy=0.
REQ-028 A reset in BUSY or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-029 Macro MULT_SEQ_EARLY_EXIT_EN.
REQ-030 Defined: BUSY->DONE also on the first BUSY edge where (coef_reg>>1)==0, so latency is max(1, index of highest set coefficient bit +1) edges, and i_coef==0 takes 1 edge.
REQ-031 Undefined: latency is always exactly COEF_W edges (REQ-019); the results are bit-identical in both builds.

Verification (WIDTH=32, COEF_W=16)
REQ-032 i_data0=1, i_coef=23027, i_ready=1 -> o_valid high 16 edges after acceptance (without macro), o_data0=23027, single-cycle pulse.
REQ-033 i_data0=0xFFFFFFFF, i_coef=3 -> o_data0=0xFFFFFFFD (wrap per REQ-018).
REQ-034 i_data0=5, i_coef=1: macro defined -> o_valid 1 edge after acceptance, o_data0=5; macro undefined -> 16 edges, o_data0=5.
REQ-035 i_data0=100, i_coef=700, i_ready=0 for 5 cycles after o_valid -> o_data0=70000 held stable with o_valid=1 and o_ready=0; i_valid pulses during this window ignored; IDLE on the edge i_ready=1.
REQ-036 rst asserted on the 4th BUSY edge -> o_busy=0, o_ready=1, o_valid=0, o_data0=0 the next cycle; a new i_data0=7, i_coef=6 then yields 42.
